// File: rtl/gpio_pkg.sv
// Shared GPIO types and constants used by the input-side engine and the register block.
package gpio_pkg;

  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_WIDTH       = 32;

  typedef enum logic {
    ARMING = 1'b0,
    ARMED  = 1'b1
  } gpio_in_state_t;

  typedef logic [GPIO_WIDTH-1:0] gpio_word_t;

  // Register views seen by the register block when WIDTH is 32.
  typedef struct packed {
    gpio_word_t rier;
    gpio_word_t fier;
    gpio_word_t ier;
  } gpio_irq_cfg_t;

  typedef struct packed {
    gpio_word_t idr;
    gpio_word_t isr;
    logic       irq;
  } gpio_in_status_t;

  typedef struct packed {
    logic       isr_clr;
    gpio_word_t isr_clr_mask;
  } gpio_isr_clr_t;

endpackage

// File: rtl/gpio_input_ctrl_sync.sv
// Generic N-stage, WIDTH-bit flop-chain synchronizer with synchronous active-high reset.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_input_ctrl.sv
// GPIO input engine: pad synchronization, sticky edge-interrupt status and a registered irq.
module gpio_input_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] rier,
  input  logic [WIDTH-1:0] fier,
  input  logic [WIDTH-1:0] ier,
  input  logic             isr_clr,
  input  logic [WIDTH-1:0] isr_clr_mask,
  output logic [WIDTH-1:0] idr,
  output logic [WIDTH-1:0] isr,
  output logic             irq,
  output gpio_in_state_t   dbg_state
);

  localparam int              CNT_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] ARM_CNT = CNT_W'(SYNC_STAGES + 1);

  // Handshake: none. Inputs are level-sampled every clk; isr_clr is a one-cycle
  // strobe qualifying isr_clr_mask, and repeated strobes simply clear again.

  logic [WIDTH-1:0] idr_sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] isr_q;
  logic             irq_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr_vec;

  gpio_in_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (idr_sync)
  );

  // Warm-up: the sync chain and prev only hold real pad history after
  // SYNC_STAGES+1 edges, so edges are suppressed until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (cnt_q != ARM_CNT) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      ARMING:  if (cnt_d == ARM_CNT) state_d = ARMED;
      ARMED:   state_d = ARMED;
      default: state_d = ARMING;
    endcase
  end

  assign rise    = idr_sync & ~prev_q;
  assign fall    = ~idr_sync & prev_q;
  assign evt     = (state_q == ARMED) ? ((rise & rier) | (fall & fier)) : '0;
  assign clr_vec = isr_clr ? isr_clr_mask : '0;

  // Set is OR-ed after the clear so a same-cycle event wins over W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      isr_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= idr_sync;
      isr_q  <= (isr_q & ~clr_vec) | evt;
      irq_q  <= |(isr_q & ier);
    end
  end

  assign idr       = idr_sync;
  assign isr       = isr_q;
  assign irq       = irq_q;
  assign dbg_state = state_q;

endmodule
